// File: rtl/field_unpack_pkg.sv
// Shared types and helpers for the bit-field stream unpacker.
package field_unpack_pkg;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_IDLE,
        S_REFILL,
        S_OUT
    } state_t;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_FIELD_W = 8;

    function automatic int unsigned clamp_width(input int unsigned req, input int unsigned max_w);
        return (req > max_w) ? max_w : req;
    endfunction

endpackage

// File: rtl/field_slice.sv
// Combinational variable part-select: word[off +: width], masked to width bits
// and zero-extended to FIELD_W.
module field_slice
    import field_unpack_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int CUR_W   = $clog2(WORD_W) + 1,
    parameter int REQ_W   = $clog2(FIELD_W) + 1
) (
    input  logic [WORD_W-1:0]  word,
    input  logic [CUR_W-1:0]   off,
    input  logic [REQ_W-1:0]   width,
    output logic [FIELD_W-1:0] field
);

    logic [FIELD_W-1:0] shifted;

    // Only the low FIELD_W bits of the shifted word can ever be selected.
    assign shifted = FIELD_W'(word >> off);

    generate
        for (genvar gi = 0; gi < FIELD_W; gi++) begin : g_mask
            localparam logic [REQ_W-1:0] BIT_IDX = REQ_W'(gi);
            assign field[gi] = shifted[gi] & (BIT_IDX < width);
        end
    endgenerate

endmodule

// File: rtl/field_unpacker.sv
// Bit-field stream unpacker: pulls LSB-first fields of requested width out of
// a stream of packed words; fields never straddle a word boundary.
module field_unpacker
    import field_unpack_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int CUR_W   = $clog2(WORD_W) + 1,
    parameter int REQ_W   = $clog2(FIELD_W) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic [REQ_W-1:0]   req_width,
    input  logic               req_valid,
    output logic               req_ready,
    output logic [FIELD_W-1:0] field_out,
    output logic               field_valid,
    input  logic               field_ready,
    output logic [CUR_W-1:0]   cursor
);

    state_t             state_reg, state_next;
    logic [WORD_W-1:0]  word_reg, word_next;
    logic [CUR_W-1:0]   cursor_reg, cursor_next;
    logic [REQ_W-1:0]   width_reg, width_next;
    logic [FIELD_W-1:0] field_reg, field_next;

    logic [REQ_W-1:0]   req_w_clamped;
    logic [CUR_W:0]     cursor_sum;
    logic               field_fits;
    logic [WORD_W-1:0]  slice_word;
    logic [CUR_W-1:0]   slice_off;
    logic [REQ_W-1:0]   slice_width;
    logic [FIELD_W-1:0] slice_field;

    assign req_w_clamped = REQ_W'(clamp_width(32'(req_width), FIELD_W));

    // One extra bit so cursor + width cannot wrap past WORD_W.
    assign cursor_sum = (CUR_W+1)'(cursor_reg) + (CUR_W+1)'(req_w_clamped);
    assign field_fits = (cursor_sum <= (CUR_W+1)'(WORD_W));

    // A refill extracts straight from the incoming word at offset 0.
    assign slice_word  = (state_reg == S_REFILL) ? word_in : word_reg;
    assign slice_off   = (state_reg == S_REFILL) ? '0 : cursor_reg;
    assign slice_width = (state_reg == S_REFILL) ? width_reg : req_w_clamped;

    field_slice #(
        .WORD_W  (WORD_W),
        .FIELD_W (FIELD_W),
        .CUR_W   (CUR_W),
        .REQ_W   (REQ_W)
    ) u_slice (
        .word  (slice_word),
        .off   (slice_off),
        .width (slice_width),
        .field (slice_field)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_EMPTY;
            word_reg   <= '0;
            cursor_reg <= '0;
            width_reg  <= '0;
            field_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            word_reg   <= word_next;
            cursor_reg <= cursor_next;
            width_reg  <= width_next;
            field_reg  <= field_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        word_next   = word_reg;
        cursor_next = cursor_reg;
        width_next  = width_reg;
        field_next  = field_reg;
        if (flush) begin
            // field_reg deliberately keeps its last value across a flush.
            state_next  = S_EMPTY;
            cursor_next = '0;
            width_next  = '0;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (word_valid) begin
                        word_next   = word_in;
                        cursor_next = '0;
                        state_next  = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        width_next = req_w_clamped;
                        if (field_fits) begin
                            field_next  = slice_field;
                            cursor_next = cursor_sum[CUR_W-1:0];
                            state_next  = S_OUT;
                        end else begin
                            cursor_next = '0;
                            state_next  = S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (word_valid) begin
                        word_next   = word_in;
                        field_next  = slice_field;
                        cursor_next = CUR_W'(width_reg);
                        state_next  = S_OUT;
                    end
                end
                S_OUT: begin
                    if (field_ready) begin
                        state_next = (cursor_reg == CUR_W'(WORD_W)) ? S_EMPTY : S_IDLE;
                    end
                end
                default: state_next = S_EMPTY;
            endcase
        end
    end

    assign word_ready  = (state_reg == S_EMPTY) || (state_reg == S_REFILL);
    assign req_ready   = (state_reg == S_IDLE);
    assign field_valid = (state_reg == S_OUT);
    assign field_out   = field_reg;
    assign cursor      = cursor_reg;

endmodule

// File: tb/tb_field_unpacker.sv
// Randomized self-checking bench for field_unpacker against a bit-stream model.
module tb_field_unpacker;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 8;
    localparam int CUR_W   = 6;
    localparam int REQ_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic [WORD_W-1:0]  word_in = '0;
    logic               word_valid = 1'b0;
    logic               word_ready;
    logic [REQ_W-1:0]   req_width = '0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [FIELD_W-1:0] field_out;
    logic               field_valid;
    logic               field_ready = 1'b0;
    logic [CUR_W-1:0]   cursor;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current word, bit cursor, and whether a word is loaded.
    logic [31:0] m_word;
    int unsigned m_cursor;
    bit          m_have;
    logic [31:0] dq[$];

    field_unpacker #(
        .WORD_W (WORD_W), .FIELD_W (FIELD_W), .CUR_W (CUR_W), .REQ_W (REQ_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .req_width   (req_width),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .field_out   (field_out),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .cursor      (cursor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] next_word();
        if (dq.size() > 0) return dq.pop_front();
        return $urandom;
    endfunction

    function automatic logic [31:0] low_mask(input int unsigned w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send_word(input logic [31:0] wd);
        int n = 0;
        word_in = wd;
        word_valid = 1'b1;
        while (!word_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!word_ready) check("word_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic issue_req(input int unsigned r);
        int n = 0;
        req_width = REQ_W'(r);
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_request(input int unsigned r, input int hold);
        int unsigned w;
        logic [31:0] exp_field;
        logic [31:0] wd;
        bit refilled = 0;
        logic [FIELD_W-1:0] held;
        if (!m_have) begin
            wd = next_word();
            send_word(wd);
            m_word = wd; m_cursor = 0; m_have = 1;
            check("load_req_ready", {31'd0, req_ready}, 32'd1);
            check("load_no_field", {31'd0, field_valid}, 32'd0);
        end
        w = (r > FIELD_W) ? FIELD_W : r;
        issue_req(r);
        if (m_cursor + w <= WORD_W) begin
            exp_field = (m_word >> m_cursor) & low_mask(w);
            m_cursor += w;
        end else begin
            check("refill_word_ready", {31'd0, word_ready}, 32'd1);
            check("refill_no_field", {31'd0, field_valid}, 32'd0);
            wd = next_word();
            send_word(wd);
            m_word = wd;
            exp_field = wd & low_mask(w);
            m_cursor = w;
            refilled = 1;
        end
        check("field_valid", {31'd0, field_valid}, 32'd1);
        check("field_out", {24'd0, field_out}, exp_field);
        check("cursor", {26'd0, cursor}, m_cursor);
        check("out_req_ready", {31'd0, req_ready}, 32'd0);
        check("out_word_ready", {31'd0, word_ready}, 32'd0);
        held = field_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_field_out", {24'd0, field_out}, {24'd0, held});
            check("bp_field_valid", {31'd0, field_valid}, 32'd1);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_word_ready", {31'd0, word_ready}, 32'd0);
        end
        field_ready = 1'b1;
        @(posedge clk); #1;
        field_ready = 1'b0;
        check("accept_fv_drop", {31'd0, field_valid}, 32'd0);
        if (m_cursor == WORD_W) begin
            check("empty_word_ready", {31'd0, word_ready}, 32'd1);
            m_have = 0;
        end else begin
            check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        end
        $display("req w=%0d field=0x%0h exp=0x%0h cursor=%0d refill=%0d hold=%0d",
                 r, field_out, exp_field, m_cursor, refilled, hold);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_have = 0;
    endtask

    initial begin
        logic [FIELD_W-1:0] held;
        m_have = 0; m_cursor = 0; m_word = '0;

        #12;
        check("rst_word_ready", {31'd0, word_ready}, 32'd1);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_field_valid", {31'd0, field_valid}, 32'd0);
        check("rst_field_out", {24'd0, field_out}, 32'd0);
        check("rst_cursor", {26'd0, cursor}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Walk one word to exhaustion, with backpressure on the second field.
        dq.push_back(32'hDEADBEEF);
        do_request(4, 0);
        do_request(4, 3);
        do_request(8, 0);
        do_request(8, 0);
        do_request(8, 0);

        // Cursor 28 then width 8 forces a refill.
        dq.push_back(32'hDEADBEEF);
        dq.push_back(32'h12345678);
        do_request(4, 0);
        do_request(8, 0);
        do_request(8, 0);
        do_request(8, 0);
        do_request(8, 1);
        do_request(0, 0);
        do_request(12, 0);

        for (int i = 0; i < 200; i++)
            do_request($urandom_range(0, 12), $urandom_range(0, 2));

        // Flush while waiting for a refill word.
        pulse_flush();
        dq.push_back(32'hA5A55A5A);
        do_request(8, 0);
        do_request(8, 0);
        do_request(8, 0);
        do_request(4, 0);
        issue_req(8);
        check("pre_flush_word_ready", {31'd0, word_ready}, 32'd1);
        check("pre_flush_no_field", {31'd0, field_valid}, 32'd0);
        held = field_out;
        word_in = 32'hFFFFFFFF;
        word_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        word_valid = 1'b0;
        m_have = 0;
        check("flush_word_ready", {31'd0, word_ready}, 32'd1);
        check("flush_no_field", {31'd0, field_valid}, 32'd0);
        check("flush_cursor", {26'd0, cursor}, 32'd0);
        check("flush_field_held", {24'd0, field_out}, {24'd0, held});
        $display("flush in refill: cursor=%0d field_out=0x%0h", cursor, field_out);
        dq.push_back(32'h1234567C);
        do_request(4, 0);

        // Asynchronous reset while a field is being presented.
        pulse_flush();
        send_word(32'hDEADBEEF);
        issue_req(8);
        check("pre_rst_field_valid", {31'd0, field_valid}, 32'd1);
        check("pre_rst_field", {24'd0, field_out}, 32'hEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_field_valid", {31'd0, field_valid}, 32'd0);
        check("arst_field_out", {24'd0, field_out}, 32'd0);
        check("arst_cursor", {26'd0, cursor}, 32'd0);
        check("arst_word_ready", {31'd0, word_ready}, 32'd1);
        check("arst_req_ready", {31'd0, req_ready}, 32'd0);
        $display("async reset in S_OUT: field_valid=%0d cursor=%0d", field_valid, cursor);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_have = 0;
        dq.push_back(32'h0000_00A7);
        do_request(4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
